// File: rtl/rib_arbiter_pkg.sv
// Shared encodings for the RIB bus arbiter: hold codes, master indices, FSM states.
package rib_arbiter_pkg;

  // Pipeline hold codes, identical to the pipeline-register hold_flag_i encoding
  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  // Master indices
  localparam int         RIB_NM      = 3;
  localparam logic [1:0] RIB_M_DBG   = 2'd0;
  localparam logic [1:0] RIB_M_DATA  = 2'd1;
  localparam logic [1:0] RIB_M_FETCH = 2'd2;

  // Arbiter FSM encodings
  localparam logic [0:0] RIB_ARB_IDLE  = 1'b0;
  localparam logic [0:0] RIB_ARB_GRANT = 1'b1;

endpackage

// File: rtl/rib_prio_sel.sv
// Combinational winner pick: M0 > M1 > M2, with M2 promoted above M1 when starved.
module rib_prio_sel
  import rib_arbiter_pkg::*;
(
  input  logic [RIB_NM-1:0] req_i,
  input  logic              starve_i,
  output logic [RIB_NM-1:0] gnt_o,
  output logic [1:0]        idx_o
);

  // Fixed priority with a starvation override for instruction fetch
  always_comb begin
    gnt_o = '0;
    idx_o = RIB_M_DBG;
    if (req_i[RIB_M_DBG]) begin
      gnt_o[RIB_M_DBG] = 1'b1;
      idx_o            = RIB_M_DBG;
    end else if (req_i[RIB_M_FETCH] && (starve_i || !req_i[RIB_M_DATA])) begin
      gnt_o[RIB_M_FETCH] = 1'b1;
      idx_o              = RIB_M_FETCH;
    end else if (req_i[RIB_M_DATA]) begin
      gnt_o[RIB_M_DATA] = 1'b1;
      idx_o             = RIB_M_DATA;
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// RIB system-bus arbiter: three masters share one slave port, one transaction at a time.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RIB_NM-1:0]        m_req_i,
  input  logic [RIB_NM-1:0]        m_we_i,
  input  logic [RIB_NM*ADDR_W-1:0] m_addr_i,
  input  logic [RIB_NM*DATA_W-1:0] m_wdata_i,
  output logic [DATA_W-1:0]        m_rdata_o,
  output logic [RIB_NM-1:0]        m_ack_o,
  output logic [RIB_NM-1:0]        m_err_o,
  output logic                     s_req_o,
  output logic                     s_we_o,
  output logic [ADDR_W-1:0]        s_addr_o,
  output logic [DATA_W-1:0]        s_wdata_o,
  input  logic [DATA_W-1:0]        s_rdata_i,
  input  logic                     s_ack_i,
  output logic [2:0]               hold_flag_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [0:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [STV_W-1:0]  starve_q, starve_d;

  logic [RIB_NM-1:0] sel_gnt;
  logic [1:0]        sel_idx;
  logic              starve;
  logic              in_grant, ack_hit, tmo_hit;
  logic [RIB_NM-1:0] own_oh;

  assign starve   = (starve_q == STV_W'(STARVE_LIMIT));
  assign in_grant = (state_q == RIB_ARB_GRANT);
  assign ack_hit  = in_grant && s_ack_i;
  // A same-cycle ack beats the timeout
  assign tmo_hit  = in_grant && !s_ack_i && (tmo_q == TMO_W'(TIMEOUT));
  assign own_oh   = 3'b001 << owner_q;

  rib_prio_sel u_sel (
    .req_i    (m_req_i),
    .starve_i (starve),
    .gnt_o    (sel_gnt),
    .idx_o    (sel_idx)
  );

  // Next-state: arbitration in IDLE, completion/timeout in GRANT, starvation tracking
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tmo_d    = tmo_q;
    starve_d = starve_q;
    if (state_q == RIB_ARB_IDLE) begin
      if (|sel_gnt) begin
        state_d = RIB_ARB_GRANT;
        owner_d = sel_idx;
        tmo_d   = '0;
      end
    end else begin
      if (s_ack_i || tmo_hit) state_d = RIB_ARB_IDLE;
      else                    tmo_d   = tmo_q + 1'b1;
    end
    if (!m_req_i[RIB_M_FETCH])
      starve_d = '0;
    else if (state_q == RIB_ARB_IDLE && sel_gnt[RIB_M_FETCH])
      starve_d = '0;
    else if (state_q == RIB_ARB_IDLE && sel_gnt[RIB_M_DATA] && !starve)
      starve_d = starve_q + 1'b1;
  end

  // State registers; reset also drops s_req_o asynchronously through state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RIB_ARB_IDLE;
      owner_q  <= '0;
      tmo_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      tmo_q    <= tmo_d;
      starve_q <= starve_d;
    end
  end

  // Slave-side mux from the registered owner; quiet outside GRANT
  always_comb begin
    s_req_o   = in_grant;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (in_grant) begin
      case (owner_q)
        RIB_M_DBG: begin
          s_we_o    = m_we_i[0];
          s_addr_o  = m_addr_i[0*ADDR_W +: ADDR_W];
          s_wdata_o = m_wdata_i[0*DATA_W +: DATA_W];
        end
        RIB_M_DATA: begin
          s_we_o    = m_we_i[1];
          s_addr_o  = m_addr_i[1*ADDR_W +: ADDR_W];
          s_wdata_o = m_wdata_i[1*DATA_W +: DATA_W];
        end
        default: begin
          s_we_o    = m_we_i[2];
          s_addr_o  = m_addr_i[2*ADDR_W +: ADDR_W];
          s_wdata_o = m_wdata_i[2*DATA_W +: DATA_W];
        end
      endcase
    end
  end

  // Completion pulses go only to an owner that is still requesting
  assign m_ack_o   = {RIB_NM{ack_hit}} & own_oh & m_req_i;
  assign m_err_o   = {RIB_NM{tmo_hit}} & own_oh & m_req_i;
  assign m_rdata_o = (|m_ack_o) ? s_rdata_i : '0;

  // Pipeline hold: data-path stall first, debug ownership, then fetch stall
  always_comb begin
    hold_flag_o = HOLD_NONE;
    if (!rst_n)
      hold_flag_o = HOLD_NONE;
    else if (m_req_i[RIB_M_DATA] && !(ack_hit && owner_q == RIB_M_DATA))
      hold_flag_o = HOLD_ID;
    else if (in_grant && owner_q == RIB_M_DBG)
      hold_flag_o = HOLD_ID;
    else if (m_req_i[RIB_M_FETCH] && !(ack_hit && owner_q == RIB_M_FETCH))
      hold_flag_o = HOLD_IF;
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: latency, priority, starvation, timeout, reset, suppression.
module tb_rib_arbiter;
  import rib_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 255;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      m_req_i, m_we_i;
  logic [3*AW-1:0] m_addr_i;
  logic [3*DW-1:0] m_wdata_i;
  logic [DW-1:0]   m_rdata_o;
  logic [2:0]      m_ack_o, m_err_o;
  logic            s_req_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o, s_rdata_i;
  logic            s_ack_i;
  logic [2:0]      hold_flag_o;

  int n_chk = 0;
  int n_err = 0;
  int early;

  rib_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Step to just after the next rising edge (inputs change here)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point away from the active edge
  task automatic smp();
    @(negedge clk);
  endtask

  logic [2:0] seq [6];

  initial begin
    seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010};
    rst_n = 1'b0; m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0;
    s_rdata_i = '0; s_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_sreq", s_req_o, 0);
    chk("rst_ack",  m_ack_o, 0);
    chk("rst_err",  m_err_o, 0);
    chk("rst_hold", hold_flag_o, HOLD_NONE);
    rst_n = 1'b1;

    // M1 read of 0x1000, slave acks in the second GRANT cycle
    cyc(); m_addr_i[1*AW +: AW] = 32'h1000; m_req_i = 3'b010; smp();
    chk("t1_idle_sreq", s_req_o, 0);
    chk("t1_idle_hold", hold_flag_o, HOLD_ID);
    cyc(); smp();
    chk("t1_g1_sreq", s_req_o, 1);
    chk("t1_g1_addr", s_addr_o, 32'h1000);
    chk("t1_g1_hold", hold_flag_o, HOLD_ID);
    chk("t1_g1_ack",  m_ack_o, 0);
    cyc(); s_ack_i = 1'b1; s_rdata_i = 32'hDEADBEEF; smp();
    chk("t1_ack",   m_ack_o, 3'b010);
    chk("t1_rdata", m_rdata_o, 32'hDEADBEEF);
    chk("t1_hold",  hold_flag_o, HOLD_NONE);
    cyc(); m_req_i = '0; s_ack_i = 1'b0; smp();
    chk("t1_idle2", s_req_o, 0);

    // All three request together, zero-wait slave
    cyc();
    m_addr_i = {32'h300, 32'h200, 32'h100}; m_we_i = 3'b010;
    m_wdata_i[1*DW +: DW] = 32'hCAFEF00D;
    m_req_i = 3'b111; s_ack_i = 1'b1; s_rdata_i = 32'h11; smp();
    chk("t2_c0_ack", m_ack_o, 0);
    cyc(); smp();
    chk("t2_m0_ack",  m_ack_o, 3'b001);
    chk("t2_m0_addr", s_addr_o, 32'h100);
    chk("t2_m0_we",   s_we_o, 0);
    chk("t2_m0_hold", hold_flag_o, HOLD_ID);
    cyc(); m_req_i = 3'b110; smp();
    chk("t2_gap1", s_req_o, 0);
    cyc(); smp();
    chk("t2_m1_ack",   m_ack_o, 3'b010);
    chk("t2_m1_addr",  s_addr_o, 32'h200);
    chk("t2_m1_we",    s_we_o, 1);
    chk("t2_m1_wdata", s_wdata_o, 32'hCAFEF00D);
    chk("t2_m1_hold",  hold_flag_o, HOLD_IF);
    cyc(); m_req_i = 3'b100; smp();
    chk("t2_gap2", s_req_o, 0);
    cyc(); smp();
    chk("t2_m2_ack",  m_ack_o, 3'b100);
    chk("t2_m2_addr", s_addr_o, 32'h300);
    chk("t2_m2_hold", hold_flag_o, HOLD_NONE);
    cyc(); m_req_i = '0; s_ack_i = 1'b0; m_we_i = '0; smp();

    // Starvation: M1 continuous, M2 pending
    cyc(); m_req_i = 3'b110; s_ack_i = 1'b1; smp();
    for (int i = 0; i < 6; i++) begin
      cyc(); smp();
      chk($sformatf("t3_gnt%0d", i), m_ack_o, seq[i]);
      cyc(); if (seq[i] == 3'b100) m_req_i = 3'b010; smp();
      chk($sformatf("t3_gap%0d", i), s_req_o, 0);
    end
    cyc(); smp();
    chk("t3_tail", m_ack_o, 3'b010);
    cyc(); m_req_i = '0; s_ack_i = 1'b0; smp();

    // Timeout on M0 with M1 waiting behind it
    cyc(); m_req_i = 3'b011; smp();
    early = 0;
    repeat (TMO) begin
      cyc(); smp();
      if (m_err_o !== 3'b000 || s_req_o !== 1'b1) early++;
    end
    chk("t4_no_early", early, 0);
    cyc(); smp();
    chk("t4_err",  m_err_o, 3'b001);
    chk("t4_noack", m_ack_o, 0);
    cyc(); m_req_i = 3'b010; s_ack_i = 1'b1; smp();
    chk("t4_drop", s_req_o, 0);
    chk("t4_err_once", m_err_o, 0);
    cyc(); smp();
    chk("t4_next", m_ack_o, 3'b010);
    cyc(); m_req_i = '0; s_ack_i = 1'b0; smp();

    // Reset in the third GRANT cycle
    cyc(); m_req_i = 3'b010; smp();
    cyc(); smp();
    cyc(); smp();
    cyc();
    chk("t5_pre", s_req_o, 1);
    #1 rst_n = 1'b0; m_req_i = 3'b100;
    #1;
    chk("t5_sreq", s_req_o, 0);
    chk("t5_ack",  m_ack_o, 0);
    chk("t5_err",  m_err_o, 0);
    chk("t5_hold", hold_flag_o, HOLD_NONE);
    smp(); rst_n = 1'b1; s_ack_i = 1'b1;
    cyc(); smp();
    chk("t5_m2_ack",  m_ack_o, 3'b100);
    chk("t5_m2_addr", s_addr_o, 32'h300);
    cyc(); m_req_i = '0; s_ack_i = 1'b0; smp();

    // Ack arriving in the timeout cycle wins
    cyc(); m_req_i = 3'b001; smp();
    repeat (TMO) cyc();
    cyc(); s_ack_i = 1'b1; smp();
    chk("t6_ack", m_ack_o, 3'b001);
    chk("t6_err", m_err_o, 0);
    cyc(); m_req_i = '0; s_ack_i = 1'b0; smp();
    chk("t6_idle", s_req_o, 0);

    // Owner withdraws mid-GRANT: slave still finishes, no master pulse
    cyc(); m_req_i = 3'b100; smp();
    cyc(); m_req_i = '0; smp();
    chk("t7_sreq", s_req_o, 1);
    chk("t7_hold", hold_flag_o, HOLD_NONE);
    cyc(); s_ack_i = 1'b1; s_rdata_i = 32'h55; smp();
    chk("t7_ack",   m_ack_o, 0);
    chk("t7_rdata", m_rdata_o, 0);
    cyc(); s_ack_i = 1'b0; smp();
    chk("t7_idle", s_req_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
